// File: rtl/symbol_draw_scheduler_pkg.sv
// Shared definitions for the symbol draw scheduler.
//   X_W / Y_W / SYM_W : widths of the symbol origin and symbol id fields
//   CNT_W             : width of the DRAW cycle counter
//   TIMEOUT_DEF       : default DRAW cycle limit before an abort
//   state_t           : scheduler FSM states
package symbol_draw_scheduler_pkg;

  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int SYM_W       = 2;
  localparam int CNT_W       = 6;
  localparam int TIMEOUT_DEF = 63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/symbol_draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index with highest priority; search runs upward from it and wraps
//   grant : one-hot grant (all zero when no request)
//   idx   : index of the granted requester
//   valid : at least one request present
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate index ptr+k, wrapped into 0..NREQ-1 without a modulo.
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IDX_W'(j);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/symbol_draw_scheduler.sv
// Symbol draw scheduler: arbitrates NREQ symbol draw requests round-robin and
// sequences a pixel drawer through LOAD (counter clear), DRAW and DONE.
//   clk, reset          : clock, asynchronous active-high reset
//   req                 : per-requester level request, held until ack
//   req_x/req_y/req_sym : packed per-requester origin and symbol id
//   draw_next           : drawer end-of-symbol pulse, sampled only in DRAW
//   draw_go, plot       : drawer counter enable / VGA write enable (DRAW only)
//   draw_x/y/sym        : latched origin and symbol for the active draw
//   ack, err            : one-cycle completion pulse (one-hot) and timeout flag
//   busy                : high outside IDLE
//   dbg_state           : current FSM state
// Handshake: a requester raises req[i] and holds it; the scheduler answers with
// a single-cycle ack[i] once the draw is finished (or aborted by timeout, in
// which case err pulses in the same cycle). Dropping req[i] after the grant
// does not cancel the draw.
module symbol_draw_scheduler
  import symbol_draw_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [X_W*NREQ-1:0]   req_x,
  input  logic [Y_W*NREQ-1:0]   req_y,
  input  logic [SYM_W*NREQ-1:0] req_sym,
  input  logic                  draw_next,
  output logic                  draw_go,
  output logic [X_W-1:0]        draw_x,
  output logic [Y_W-1:0]        draw_y,
  output logic [SYM_W-1:0]      draw_sym,
  output logic                  plot,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  err,
  output state_t                dbg_state
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [NREQ-1:0]  gnt;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [SYM_W-1:0] sel_sym;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Pick the winner's fields out of the packed request buses.
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_sym = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_x   = req_x[i*X_W +: X_W];
        sel_y   = req_y[i*Y_W +: Y_W];
        sel_sym = req_sym[i*SYM_W +: SYM_W];
      end
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gidx     <= '0;
      gnt      <= '0;
      cnt      <= '0;
      draw_go  <= 1'b0;
      plot     <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      draw_x   <= '0;
      draw_y   <= '0;
      draw_sym <= '0;
    end else begin
      // ack and err are single-cycle pulses; only the DRAW exit raises them.
      ack <= '0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            gidx     <= arb_idx;
            gnt      <= arb_grant;
            draw_x   <= sel_x;
            draw_y   <= sel_y;
            draw_sym <= sel_sym;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // One cycle with draw_go low clears the drawer's counter.
          cnt     <= '0;
          draw_go <= 1'b1;
          plot    <= 1'b1;
          state   <= ST_DRAW;
        end
        ST_DRAW: begin
          // draw_next wins over the timeout when both land on the same cycle.
          if (draw_next || (cnt == CNT_W'(TIMEOUT))) begin
            draw_go <= 1'b0;
            plot    <= 1'b0;
            ack     <= gnt;
            err     <= !draw_next;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          ptr   <= (gidx == IDX_W'(NREQ-1)) ? '0 : gidx + 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_draw_scheduler.sv
// Bench for symbol_draw_scheduler: a transaction-level reference model plus a
// scoreboard of hand-computed ack records {err, ack, draw_go run length}.
module tb_symbol_draw_scheduler;
  import symbol_draw_scheduler_pkg::*;

  localparam int NREQ = 4;
  localparam int TMO  = 63;
  localparam int SB_W = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req;
  logic [X_W*NREQ-1:0]   req_x;
  logic [Y_W*NREQ-1:0]   req_y;
  logic [SYM_W*NREQ-1:0] req_sym;
  logic                  draw_next;
  logic                  draw_go;
  logic [X_W-1:0]        draw_x;
  logic [Y_W-1:0]        draw_y;
  logic [SYM_W-1:0]      draw_sym;
  logic                  plot;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic                  err;
  state_t                dbg_state;

  symbol_draw_scheduler #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_sym   (req_sym),
    .draw_next (draw_next),
    .draw_go   (draw_go),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .draw_sym  (draw_sym),
    .plot      (plot),
    .ack       (ack),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // Phase of the current transaction: 0 waiting, 1 counter clear, 2 drawing,
  // 3 completion cycle. m_n counts drawing cycles already spent.
  int              m_phase = 0;
  int              m_ptr   = 0;
  int              m_g     = 0;
  int              m_n     = 0;
  bit              m_abort = 0;
  logic [X_W-1:0]   m_x   = '0;
  logic [Y_W-1:0]   m_y   = '0;
  logic [SYM_W-1:0] m_sym = '0;

  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_g = 0; m_n = 0; m_abort = 0;
      m_x = '0; m_y = '0; m_sym = '0;
    end else begin
      if (m_phase == 0) begin
        if (req != '0) begin
          m_g   = rr_pick(req, m_ptr);
          m_x   = req_x[m_g*X_W +: X_W];
          m_y   = req_y[m_g*Y_W +: Y_W];
          m_sym = req_sym[m_g*SYM_W +: SYM_W];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_n = 0;
      end else if (m_phase == 2) begin
        m_n = m_n + 1;
        if (draw_next) begin
          m_phase = 3; m_abort = 0;
        end else if (m_n == TMO + 1) begin
          m_phase = 3; m_abort = 1;
        end
      end else begin
        m_phase = 0;
        m_ptr = (m_g + 1) % NREQ;
      end
    end
  end

  // ---------------- scoreboard / counters ----------------
  logic [SB_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int run_len = 0;
  int acks_seen = 0;
  int ack_goal = 0;
  bit hold_mode = 0;
  int target = 0;
  int dcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare at the falling edge, then update drawer/requesters.
  task automatic step();
    logic [NREQ-1:0] e_ack;
    logic [SB_W-1:0] obs, e;
    @(negedge clk);
    e_ack = (m_phase == 3) ? NREQ'(1) << m_g : '0;
    chk("draw_go", 32'(draw_go), 32'(m_phase == 2));
    chk("plot", 32'(plot), 32'(m_phase == 2));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("err", 32'(err), 32'(m_phase == 3 && m_abort));
    chk("draw_x", 32'(draw_x), 32'(m_x));
    chk("draw_y", 32'(draw_y), 32'(m_y));
    chk("draw_sym", 32'(draw_sym), 32'(m_sym));
    if (reset) begin
      run_len = 0;
    end else begin
      if (draw_go) run_len++;
      if (ack != '0) begin
        obs = {err, ack, 7'(run_len)};
        if (exp_q.size() == 0) chk("unexpected_ack", 32'(obs), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_ack", 32'(obs), 32'(e));
        end
        run_len = 0;
      end
    end
    // drawer: raises draw_next in its target-th draw_go cycle (0 = never)
    if (draw_go) begin
      draw_next = (target != 0) && (dcnt == target - 1);
      dcnt++;
    end else begin
      draw_next = 1'b0;
      dcnt = 0;
    end
    // requesters: drop on ack, or hold until the ack goal is reached
    if (!reset && ack != '0) begin
      acks_seen++;
      if (!hold_mode) req = req & ~ack;
      else if (acks_seen >= ack_goal) req = '0;
    end
  endtask

  task automatic push(input bit e, input logic [NREQ-1:0] a, input int len);
    exp_q.push_back({e, a, 7'(len)});
  endtask

  task automatic start(input logic [NREQ-1:0] r, input bit hold, input int goal, input int tgt);
    acks_seen = 0; ack_goal = goal; hold_mode = hold; target = tgt;
    req = r;
  endtask

  task automatic wait_acks();
    int b;
    b = 0;
    while (acks_seen < ack_goal && b < 600) begin
      step();
      b++;
    end
    chk("ack_wait", 32'(acks_seen), 32'(ack_goal));
    step();
    step();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1;
    req = '0;
    draw_next = 1'b0;
    req_x   = {8'd200, 8'd150, 8'd90, 8'd40};
    req_y   = {7'd100, 7'd70, 7'd50, 7'd30};
    req_sym = {2'd3, 2'd2, 2'd0, 2'd1};
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_go", 32'(draw_go), 32'd0);
    chk("rst_x", 32'(draw_x), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // fairness: all four held, five 5-cycle draws
    push(0, 4'b0001, 5); push(0, 4'b0010, 5); push(0, 4'b0100, 5);
    push(0, 4'b1000, 5); push(0, 4'b0001, 5);
    start(4'b1111, 1, 5, 5);
    wait_acks();

    // single draw from requester 0, 51 draw cycles
    push(0, 4'b0001, 51);
    start(4'b0001, 0, 1, 51);
    step();
    chk("lat_load_busy", 32'(busy), 32'd1);
    chk("lat_load_go", 32'(draw_go), 32'd0);
    step();
    chk("lat_draw_go", 32'(draw_go), 32'd1);
    chk("single_x", 32'(draw_x), 32'd40);
    chk("single_y", 32'(draw_y), 32'd30);
    chk("single_sym", 32'(draw_sym), 32'd1);
    wait_acks();

    // timeout: no draw_next, 64 draw cycles then ack with err
    push(1, 4'b0100, 64);
    start(4'b0100, 0, 1, 0);
    wait_acks();

    // boundary: draw_next in the 64th draw cycle -> normal completion
    push(0, 4'b1000, 64);
    start(4'b1000, 0, 1, 64);
    wait_acks();

    // request dropped during the counter-clear cycle
    push(0, 4'b0010, 8);
    start(4'b0010, 0, 1, 8);
    step();
    req = '0;
    wait_acks();
    chk("drop_idle_busy", 32'(busy), 32'd0);
    chk("drop_idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // reset in the middle of a draw
    start(4'b0010, 0, 0, 0);
    begin
      int b;
      b = 0;
      while (dcnt < 10 && b < 100) begin
        step();
        b++;
      end
      chk("mid_draw_reached", 32'(dcnt), 32'd10);
    end
    #2 reset = 1'b1;
    #1;
    chk("rstmid_go", 32'(draw_go), 32'd0);
    chk("rstmid_plot", 32'(plot), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ack", 32'(ack), 32'd0);
    push(0, 4'b0001, 3); push(0, 4'b1000, 3);
    start(4'b1001, 0, 2, 3);
    step();
    step();
    reset = 1'b0;
    wait_acks();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
